// File: rtl/byte_packer_pkg.sv
// rtl/byte_packer_pkg.sv - shared constants and state encoding for byte_packer
package byte_packer_pkg;

  localparam int BYTE_W             = 8;
  // 256-bit ECDSA operand
  localparam int DEFAULT_WORD_BYTES = 32;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs bytes from an 8-bit fifo into WORD_BYTES-wide words
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  output logic                         fifo_r_en,
  input  logic [BYTE_W-1:0]            fifo_data_r,
  input  logic                         flush,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [BYTE_W*WORD_BYTES-1:0] word_data,
  output logic [6:0]                   byte_cnt
);

  localparam int         W      = BYTE_W * WORD_BYTES;
  localparam logic [6:0] WB_CNT = 7'(WORD_BYTES);

  logic [0:0]   state_q, state_d;
  logic [6:0]   req_cnt_q, req_cnt_d;
  logic [6:0]   byte_cnt_q, byte_cnt_d;
  logic         pend_q, pend_d;
  logic [W-1:0] word_q, word_d;
  logic [W-1:0] word_shift;

  always_comb begin
    if (MSB_FIRST) word_shift = {word_q[W-BYTE_W-1:0], fifo_data_r};
    else           word_shift = {fifo_data_r, word_q[W-1:BYTE_W]};
  end

  // Gated by rst_n so no read is issued while the upstream fifo is held in reset.
  assign fifo_r_en = rst_n && (state_q == ST_FILL) && !fifo_empty && !flush
                     && (req_cnt_q < WB_CNT);

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    pend_d     = fifo_r_en;
    if (flush) begin
      // Also drops a byte still in flight from the previous cycle's grant.
      state_d    = ST_FILL;
      req_cnt_d  = '0;
      byte_cnt_d = '0;
      word_d     = '0;
      pend_d     = 1'b0;
    end else if (state_q == ST_HOLD) begin
      if (word_ready) begin
        state_d    = ST_FILL;
        req_cnt_d  = '0;
        byte_cnt_d = '0;
        word_d     = '0;
      end
    end else begin
      if (fifo_r_en) req_cnt_d = req_cnt_q + 7'd1;
      if (pend_q) begin
        word_d     = word_shift;
        byte_cnt_d = byte_cnt_q + 7'd1;
        if (byte_cnt_q + 7'd1 == WB_CNT) state_d = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      req_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pend_q     <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pend_q     <= pend_d;
      word_q     <= word_d;
    end
  end

  assign word_valid = (state_q == ST_HOLD);
  assign word_data  = word_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - directed bench: 16-deep fifo model feeding MSB- and LSB-first packers
module tb_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        word_ready = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;

  logic [7:0]  mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  fcnt;
  logic [7:0]  fifo_data_r;
  logic        fifo_empty;

  logic        r_en_a, r_en_b, valid_a, valid_b;
  logic [31:0] data_a, data_b;
  logic [6:0]  cnt_a, cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (fcnt == 5'd0);

  // Upstream fifo: registered read data, reset together with the packers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; fcnt <= '0; fifo_data_r <= '0;
    end else begin
      if (wr_en && fcnt != 5'd16) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= wr_ptr + 4'd1;
      end
      if (r_en_a) begin
        fifo_data_r <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 4'd1;
      end
      fcnt <= fcnt + 5'((wr_en && fcnt != 5'd16) ? 1 : 0) - 5'(r_en_a ? 1 : 0);
    end
  end

  byte_packer #(.WORD_BYTES(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_r_en(r_en_a),
    .fifo_data_r(fifo_data_r), .flush(flush), .word_valid(valid_a),
    .word_ready(word_ready), .word_data(data_a), .byte_cnt(cnt_a)
  );

  byte_packer #(.WORD_BYTES(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_r_en(r_en_b),
    .fifo_data_r(fifo_data_r), .flush(flush), .word_valid(valid_b),
    .word_ready(word_ready), .word_data(data_b), .byte_cnt(cnt_b)
  );

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = first + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic collect(input int cycles, output int nvalid,
                         output logic [31:0] da, output logic [31:0] db);
    nvalid = 0; da = '0; db = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid_a) begin
        nvalid++; da = data_a; db = data_b;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_en_a, valid_a, cnt_a, data_a} !== 41'd0) begin
      errors++;
      $display("FAIL reset_in: r_en=%b valid=%b cnt=%0d data=%h want all 0", r_en_a, valid_a, cnt_a, data_a);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({r_en_a, valid_a, cnt_a, data_a} !== 41'd0) begin
      errors++;
      $display("FAIL reset_idle: r_en=%b valid=%b cnt=%0d data=%h want all 0", r_en_a, valid_a, cnt_a, data_a);
    end
  endtask

  task automatic test_single();
    int n; logic [31:0] da, db;
    word_ready = 1'b1;
    push_bytes(8'h01, 4);
    collect(15, n, da, db);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", n); end
    checks++;
    if (da !== 32'h01020304) begin errors++; $display("FAIL single_msb: got %h want 01020304", da); end
    checks++;
    if (db !== 32'h04030201) begin errors++; $display("FAIL single_lsb: got %h want 04030201", db); end
  endtask

  task automatic test_backlog();
    logic [31:0] exp_w [4];
    int waited;
    exp_w[0] = 32'h01020304; exp_w[1] = 32'h05060708;
    exp_w[2] = 32'h090A0B0C; exp_w[3] = 32'h0D0E0F10;
    word_ready = 1'b0;
    push_bytes(8'h01, 16);
    repeat (3) @(negedge clk);
    checks++;
    if (fcnt !== 5'd12) begin errors++; $display("FAIL backlog_fifo_level: got %0d want 12", fcnt); end
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (!valid_a && waited < 20) begin @(negedge clk); waited++; end
      checks++;
      if (!valid_a) begin
        errors++; $display("FAIL backlog_timeout: word %0d never valid", k);
      end else if (data_a !== exp_w[k]) begin
        errors++; $display("FAIL backlog_word%0d: got %h want %h", k, data_a, exp_w[k]);
      end
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || data_a !== exp_w[k]) begin
        errors++; $display("FAIL backlog_hold%0d: valid=%b data=%h want 1 %h", k, valid_a, data_a, exp_w[k]);
      end
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fcnt !== 5'd0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL backlog_end: fifo=%0d valid=%b want 0 0", fcnt, valid_a);
    end
  endtask

  task automatic test_gap();
    int n; logic [31:0] da, db;
    word_ready = 1'b1;
    push_bytes(8'h01, 2);
    repeat (4) @(negedge clk);
    checks++;
    if (cnt_a !== 7'd2) begin errors++; $display("FAIL gap_cnt_early: got %0d want 2", cnt_a); end
    repeat (6) @(negedge clk);
    checks++;
    if (cnt_a !== 7'd2 || r_en_a !== 1'b0) begin
      errors++; $display("FAIL gap_cnt_late: cnt=%0d r_en=%b want 2 0", cnt_a, r_en_a);
    end
    push_bytes(8'h03, 2);
    collect(12, n, da, db);
    checks++;
    if (n !== 1 || da !== 32'h01020304) begin
      errors++; $display("FAIL gap_word: n=%0d data=%h want 1 01020304", n, da);
    end
  endtask

  task automatic test_flush();
    int n; logic [31:0] da, db;
    word_ready = 1'b1;
    push_bytes(8'h01, 2);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (cnt_a !== 7'd0 || data_a !== 32'd0) begin
      errors++; $display("FAIL flush_clear: cnt=%0d data=%h want 0 0", cnt_a, data_a);
    end
    push_bytes(8'h05, 4);
    collect(15, n, da, db);
    checks++;
    if (n !== 1 || da !== 32'h05060708) begin
      errors++; $display("FAIL flush_word: n=%0d data=%h want 1 05060708", n, da);
    end
    // flush in HOLD wins over a simultaneous word_ready
    word_ready = 1'b0;
    push_bytes(8'h21, 4);
    repeat (4) @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 32'h21222324) begin
      errors++; $display("FAIL hold_before_flush: valid=%b data=%h want 1 21222324", valid_a, data_a);
    end
    flush = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; word_ready = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || cnt_a !== 7'd0 || data_a !== 32'd0) begin
      errors++; $display("FAIL hold_flush: valid=%b cnt=%0d data=%h want 0 0 0", valid_a, cnt_a, data_a);
    end
  endtask

  task automatic test_reset_mid();
    int n, waited; logic [31:0] da, db;
    word_ready = 1'b1;
    push_bytes(8'h01, 3);
    waited = 0;
    while (cnt_a !== 7'd3 && waited < 10) begin @(negedge clk); waited++; end
    checks++;
    if (cnt_a !== 7'd3) begin errors++; $display("FAIL rstmid_prefill: cnt=%0d want 3", cnt_a); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_en_a, valid_a, cnt_a, data_a} !== 41'd0) begin
      errors++; $display("FAIL rstmid_outputs: r_en=%b valid=%b cnt=%0d data=%h want all 0", r_en_a, valid_a, cnt_a, data_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_bytes(8'h09, 4);
    collect(15, n, da, db);
    checks++;
    if (n !== 1 || da !== 32'h090A0B0C || db !== 32'h0C0B0A09) begin
      errors++; $display("FAIL rstmid_word: n=%0d msb=%h lsb=%h want 1 090a0b0c 0c0b0a09", n, da, db);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backlog();
    test_gap();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
